// File: rtl/istream_prefetch_pkg.sv
// Shared definitions for the instruction-stream prefetcher: FSM encoding, default
// geometry and the block READ/BUSYWAIT handshake levels used by icache and imem.
package istream_prefetch_pkg;

    localparam int unsigned AddrWDefault  = 6;
    localparam int unsigned BlockWDefault = 128;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StDemand   = 2'b01,
        StRespond  = 2'b10,
        StPrefetch = 2'b11
    } state_e;

    localparam logic MemReadOn  = 1'b1;
    localparam logic MemReadOff = 1'b0;
    localparam logic MemBusy    = 1'b1;
    localparam logic MemReady   = 1'b0;

endpackage

// File: rtl/istream_prefetch_if.sv
// Block-granular READ/BUSYWAIT bus; the same shape serves icache->prefetcher and
// prefetcher->instruction memory.
interface istream_prefetch_if import istream_prefetch_pkg::*; #(
    parameter int unsigned AddrW  = AddrWDefault,
    parameter int unsigned BlockW = BlockWDefault
) ();

    logic              read;
    logic [AddrW-1:0]  address;
    logic [BlockW-1:0] readdata;
    logic              busywait;

    modport master (
        output read,
        output address,
        input  readdata,
        input  busywait
    );

    modport slave (
        input  read,
        input  address,
        output readdata,
        output busywait
    );

endinterface

// File: rtl/istream_prefetch_pbuf_entry.sv
// One-entry stream buffer: holds a prefetched block, reports a hit for a lookup
// address, and is invalidated when the hit is consumed.
module istream_prefetch_pbuf_entry #(
    parameter int unsigned AddrW  = 6,
    parameter int unsigned BlockW = 128
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_i,
    input  logic [AddrW-1:0]  wr_addr_i,
    input  logic [BlockW-1:0] wr_data_i,
    input  logic              consume_i,
    input  logic [AddrW-1:0]  lookup_addr_i,
    output logic              hit_o,
    output logic [BlockW-1:0] data_o
);

    logic              valid_q;
    logic [AddrW-1:0]  addr_q;
    logic [BlockW-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (wr_i) begin
            valid_q <= 1'b1;
            addr_q  <= wr_addr_i;
            data_q  <= wr_data_i;
        end else if (consume_i) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_o  = valid_q && (addr_q == lookup_addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/istream_prefetch.sv
// Next-block instruction prefetcher: forwards icache misses to memory, then fetches
// the following block into a one-entry stream buffer that can answer in one cycle.
module istream_prefetch import istream_prefetch_pkg::*; #(
    parameter int unsigned ADDR_W      = AddrWDefault,
    parameter int unsigned BLOCK_W     = BlockWDefault,
    parameter bit          PREFETCH_EN = 1'b1
) (
    input logic              CLK,
    input logic              RESET,
    istream_prefetch_if.slave  c_bus,
    istream_prefetch_if.master m_bus
);

    state_e               state_q, state_d;
    logic [BLOCK_W-1:0]   out_q, out_d;
    logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
    logic                 seen_busy_q, seen_busy_d;
    logic                 m_read_q, m_read_d;
    logic [ADDR_W-1:0]    m_addr_q, m_addr_d;

    logic                 pbuf_hit;
    logic                 pbuf_wr;
    logic                 pbuf_consume;
    logic [BLOCK_W-1:0]   pbuf_data;

    istream_prefetch_pbuf_entry #(
        .AddrW  (ADDR_W),
        .BlockW (BLOCK_W)
    ) u_pbuf (
        .clk_i         (CLK),
        .rst_ni        (RESET),
        .wr_i          (pbuf_wr),
        .wr_addr_i     (m_addr_q),
        .wr_data_i     (m_bus.readdata),
        .consume_i     (pbuf_consume),
        .lookup_addr_i (c_bus.address),
        .hit_o         (pbuf_hit),
        .data_o        (pbuf_data)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= StIdle;
            out_q       <= '0;
            req_addr_q  <= '0;
            seen_busy_q <= 1'b0;
            m_read_q    <= MemReadOff;
            m_addr_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            req_addr_q  <= req_addr_d;
            seen_busy_q <= seen_busy_d;
            m_read_q    <= m_read_d;
            m_addr_q    <= m_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        req_addr_d   = req_addr_q;
        seen_busy_d  = seen_busy_q;
        m_read_d     = m_read_q;
        m_addr_d     = m_addr_q;
        pbuf_wr      = 1'b0;
        pbuf_consume = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (c_bus.read) begin
                    if (pbuf_hit) begin
                        out_d        = pbuf_data;
                        pbuf_consume = 1'b1;
                        req_addr_d   = c_bus.address;
                        state_d      = StRespond;
                    end else if (m_bus.busywait == MemReady) begin
                        // Held off while memory may still finish a pre-reset transaction.
                        req_addr_d  = c_bus.address;
                        m_read_d    = MemReadOn;
                        m_addr_d    = c_bus.address;
                        seen_busy_d = 1'b0;
                        state_d     = StDemand;
                    end
                end
            end
            StDemand, StPrefetch: begin
                if (m_bus.busywait == MemBusy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    m_read_d = MemReadOff;
                    if (state_q == StDemand) begin
                        out_d   = m_bus.readdata;
                        state_d = StRespond;
                    end else begin
                        pbuf_wr = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StRespond: begin
                if (PREFETCH_EN) begin
                    m_read_d    = MemReadOn;
                    m_addr_d    = req_addr_q + 1'b1;
                    seen_busy_d = 1'b0;
                    state_d     = StPrefetch;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign c_bus.readdata = out_q;
    assign c_bus.busywait = c_bus.read && (state_q != StRespond);
    assign m_bus.read     = m_read_q;
    assign m_bus.address  = m_addr_q;

endmodule

// File: tb/tb_istream_prefetch.sv
// Bench for istream_prefetch: directed vector table, multi-cycle corner sequences and
// a random request stream checked against a transaction-level prefetch model.
module tb_istream_prefetch;

    localparam int unsigned AW = 6;
    localparam int unsigned BW = 128;
    localparam logic [BW-1:0] Junk = {4{32'hBAD0_BAD0}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    istream_prefetch_if #(.AddrW(AW), .BlockW(BW)) c0 ();
    istream_prefetch_if #(.AddrW(AW), .BlockW(BW)) m0 ();
    istream_prefetch_if #(.AddrW(AW), .BlockW(BW)) c1 ();
    istream_prefetch_if #(.AddrW(AW), .BlockW(BW)) m1 ();

    istream_prefetch #(.ADDR_W(AW), .BLOCK_W(BW), .PREFETCH_EN(1'b1)) dut0 (
        .CLK   (clk),
        .RESET (rst_n),
        .c_bus (c0),
        .m_bus (m0)
    );

    istream_prefetch #(.ADDR_W(AW), .BLOCK_W(BW), .PREFETCH_EN(1'b0)) dut1 (
        .CLK   (clk),
        .RESET (rst_n),
        .c_bus (c1),
        .m_bus (m1)
    );

    int total = 0;
    int bad = 0;
    int unsigned busy_len = 5;
    logic [AW-1:0] mem_log[$];

    function automatic logic [BW-1:0] blk(input logic [AW-1:0] a);
        return {4{24'hC0DE00, 2'b00, a}};
    endfunction

    // Instruction memory: busy rises as soon as READ is seen, stays up busy_len cycles,
    // then holds data until READ drops.
    logic          mrd     [2];
    logic [AW-1:0] madr    [2];
    logic          mbusy_q [2] = '{1'b0, 1'b0};
    logic          mdone_q [2] = '{1'b0, 1'b0};
    int unsigned   mcnt    [2] = '{0, 0};
    logic [AW-1:0] mlat    [2] = '{'0, '0};
    logic [BW-1:0] mrdata  [2] = '{'0, '0};

    assign mrd[0]  = m0.read;
    assign mrd[1]  = m1.read;
    assign madr[0] = m0.address;
    assign madr[1] = m1.address;
    assign m0.busywait = mbusy_q[0] | (m0.read & ~mdone_q[0]);
    assign m1.busywait = mbusy_q[1] | (m1.read & ~mdone_q[1]);
    assign m0.readdata = mrdata[0];
    assign m1.readdata = mrdata[1];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mbusy_q[i]) begin
                if (mcnt[i] <= 1) begin
                    mbusy_q[i] <= 1'b0;
                    mdone_q[i] <= 1'b1;
                    mrdata[i]  <= blk(mlat[i]);
                end else begin
                    mcnt[i] <= mcnt[i] - 1;
                end
            end else if (mrd[i] && !mdone_q[i]) begin
                mbusy_q[i] <= 1'b1;
                mcnt[i]    <= busy_len - 1;
                mlat[i]    <= madr[i];
                mrdata[i]  <= Junk;
                if (i == 0) mem_log.push_back(madr[i]);
            end else if (!mrd[i]) begin
                mdone_q[i] <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic req(input int which, input logic [AW-1:0] a, output int lat,
                       output logic [BW-1:0] d);
        bit got = 1'b0;
        lat = 0;
        d = '0;
        if (which == 0) begin c0.address = a; c0.read = 1'b1; end
        else begin c1.address = a; c1.read = 1'b1; end
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (which == 0 ? !c0.busywait : !c1.busywait) begin
                got = 1'b1;
                d = (which == 0) ? c0.readdata : c1.readdata;
            end
        end
        if (which == 0) c0.read = 1'b0;
        else c1.read = 1'b0;
        chk("req_done", BW'(got), BW'(1));
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 200 && !ok; i++) begin
            if (!m0.read) ok = 1'b1;
            else @(negedge clk);
        end
        chk("mem_idle", BW'(ok), BW'(1));
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        int            lat;
        logic [AW-1:0] pf;
    } vec_t;

    initial begin
        vec_t          vecs [4];
        int            lat;
        logic [BW-1:0] d;
        int            mark;
        int            viol;
        int            old_cycles;
        bit            old_phase;
        bit            got;
        logic [AW-1:0] a, prev, maddr;
        bit            mvalid;
        logic [AW-1:0] expq[$];

        vecs[0] = '{addr: 6'h04, lat: 7, pf: 6'h05};
        vecs[1] = '{addr: 6'h05, lat: 1, pf: 6'h06};
        vecs[2] = '{addr: 6'h3F, lat: 7, pf: 6'h00};
        vecs[3] = '{addr: 6'h00, lat: 1, pf: 6'h01};

        c0.read = 1'b0; c0.address = '0;
        c1.read = 1'b0; c1.address = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_read", BW'(m0.read), BW'(0));
        chk("rst_m_addr", BW'(m0.address), BW'(0));
        chk("rst_c_data", c0.readdata, '0);
        chk("rst_c_busy_idle", BW'(c0.busywait), BW'(0));
        chk("rst_pbuf_valid", BW'(dut0.u_pbuf.valid_q), BW'(0));
        c0.read = 1'b1;
        #1 chk("rst_c_busy_follows", BW'(c0.busywait), BW'(1));
        c0.read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            req(0, vecs[v].addr, lat, d);
            chk($sformatf("vec%0d_lat", v), BW'(lat), BW'(vecs[v].lat));
            chk($sformatf("vec%0d_data", v), d, blk(vecs[v].addr));
            @(negedge clk);
            chk($sformatf("vec%0d_pf_read", v), BW'(m0.read), BW'(1));
            chk($sformatf("vec%0d_pf_addr", v), BW'(m0.address), BW'(vecs[v].pf));
            wait_idle();
            chk($sformatf("vec%0d_pbuf_valid", v), BW'(dut0.u_pbuf.valid_q), BW'(1));
            chk($sformatf("vec%0d_pbuf_addr", v), BW'(dut0.u_pbuf.addr_q), BW'(vecs[v].pf));
            chk($sformatf("vec%0d_pbuf_data", v), dut0.u_pbuf.data_q, blk(vecs[v].pf));
        end

        // Request for the block currently being prefetched.
        req(0, 6'h0F, lat, d);
        chk("pf_hit_pre_lat", BW'(lat), BW'(7));
        chk("pf_hit_pre_data", d, blk(6'h0F));
        @(negedge clk);
        mark = mem_log.size();
        req(0, 6'h10, lat, d);
        chk("pf_hit_lat", BW'(lat), BW'(7));
        chk("pf_hit_data", d, blk(6'h10));
        chk("pf_hit_nreads", BW'(mem_log.size() - mark), BW'(1));
        chk("pf_hit_addr", BW'(mem_log[mem_log.size() - 1]), BW'(6'h10));

        // Request for another block while 0x11 is being prefetched.
        @(negedge clk);
        req(0, 6'h20, lat, d);
        chk("pf_miss_lat", BW'(lat), BW'(13));
        chk("pf_miss_data", d, blk(6'h20));
        chk("pf_miss_pbuf_valid", BW'(dut0.u_pbuf.valid_q), BW'(1));
        chk("pf_miss_pbuf_addr", BW'(dut0.u_pbuf.addr_q), BW'(6'h11));
        chk("pf_miss_pbuf_data", dut0.u_pbuf.data_q, blk(6'h11));
        wait_idle();

        // Reset while a demand fetch is outstanding.
        c0.address = 6'h30;
        c0.read = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_demand_read", BW'(m0.read), BW'(1));
        chk("mid_demand_busy", BW'(m0.busywait), BW'(1));
        rst_n = 1'b0;
        c0.read = 1'b0;
        @(negedge clk);
        chk("rst2_m_read", BW'(m0.read), BW'(0));
        chk("rst2_m_addr", BW'(m0.address), BW'(0));
        chk("rst2_c_data", c0.readdata, '0);
        chk("rst2_c_busy", BW'(c0.busywait), BW'(0));
        chk("rst2_pbuf_valid", BW'(dut0.u_pbuf.valid_q), BW'(0));
        rst_n = 1'b1;
        c0.address = 6'h31;
        c0.read = 1'b1;
        viol = 0;
        old_cycles = 0;
        old_phase = 1'b1;
        got = 1'b0;
        d = '0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (old_phase && !m0.busywait) old_phase = 1'b0;
            if (old_phase) begin
                old_cycles++;
                if (m0.read || !c0.busywait) viol++;
            end
            if (!c0.busywait) begin
                got = 1'b1;
                d = c0.readdata;
            end
        end
        c0.read = 1'b0;
        chk("post_rst_holdoff", BW'(viol), BW'(0));
        chk("post_rst_old_busy_seen", BW'(old_cycles > 0), BW'(1));
        chk("post_rst_done", BW'(got), BW'(1));
        chk("post_rst_data", d, blk(6'h31));
        wait_idle();

        // Random stream against a transaction-level model of the memory read sequence.
        mark = mem_log.size();
        maddr = 6'h32;
        mvalid = 1'b1;
        prev = 6'h31;
        for (int n = 0; n < 40; n++) begin
            busy_len = $urandom_range(2, 6);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = ($urandom_range(0, 1) == 1) ? AW'(prev + 1) : AW'($urandom_range(0, 63));
            if (mvalid && a == maddr) mvalid = 1'b0;
            else expq.push_back(a);
            expq.push_back(AW'(a + 1));
            maddr = AW'(a + 1);
            mvalid = 1'b1;
            prev = a;
            req(0, a, lat, d);
            chk($sformatf("rand%0d_data", n), d, blk(a));
        end
        wait_idle();
        chk("rand_log_len", BW'(mem_log.size() - mark), BW'(expq.size()));
        for (int i = 0; i < expq.size() && mark + i < mem_log.size(); i++) begin
            chk($sformatf("rand_log%0d", i), BW'(mem_log[mark + i]), BW'(expq[i]));
        end

        // Prefetch disabled: demand only, every request a full miss.
        busy_len = 5;
        req(1, 6'h07, lat, d);
        chk("nopf_lat0", BW'(lat), BW'(7));
        chk("nopf_data0", d, blk(6'h07));
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (m1.read) viol++;
        end
        chk("nopf_no_read", BW'(viol), BW'(0));
        req(1, 6'h08, lat, d);
        chk("nopf_lat1", BW'(lat), BW'(7));
        chk("nopf_data1", d, blk(6'h08));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
